resume_ctrl: RTL

Generates the one-cycle `snot` resume pulse consumed by the processor control FSM while it sits in its STOP state. It sits directly upstream of the control FSM: it takes a raw, bouncing, active-low board pushbutton, synchronizes and debounces it, and arbitrates presses against the processor's halted indication. It also keeps halt/resume statistics for the board display.

---
 rtl/resume_ctrl_pkg.sv | 17 +
 rtl/resume_ctrl_key_debounce.sv | 63 ++++++
 rtl/resume_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/resume_ctrl_pkg.sv
// rtl/resume_ctrl_pkg.sv - shared state encoding and constants for resume_ctrl
//   state_t                   : IDLE / HALTED / FIRED, 2-bit encoding
//   DEBOUNCE_CYCLES_DEFAULT   : stable cycles to accept a key change (1 ms at 50 MHz)
//   HALT_COUNT_MAX            : saturation value of halt_count
package resume_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALTED = 2'd1,
        FIRED  = 2'd2
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    localparam logic [7:0] HALT_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/resume_ctrl_key_debounce.sv
// rtl/resume_ctrl_key_debounce.sv - key synchronizer, debouncer and press pulse
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active high
//   key_n   in   raw pushbutton, active low, asynchronous
//   key_db  out  debounced level, 1 = pressed
//   press   out  one-cycle pulse, registered together with the key_db rising edge
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_db,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       fill;
    logic             armed;
    logic             level;
    logic             flip;

    assign level = ~sync2;
    assign flip  = (level != key_db) && (cnt == LAST);

    // The synchronizer resets to "released", so its first two outputs after
    // reset are not real samples. fill marks when sync2 holds a real sample;
    // presses are only honoured once a genuine released level has been seen
    // with key_db low, so a key held through reset must be let go first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            cnt    <= '0;
            key_db <= 1'b0;
            press  <= 1'b0;
            fill   <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (level == key_db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt    <= '0;
                key_db <= ~key_db;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= flip && level && armed;
            if (fill[1] && !level && !key_db) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/resume_ctrl.sv
// rtl/resume_ctrl.sv - debounced pushbutton resume pulse generator with halt statistics
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active high
//   key_n       in   raw pushbutton, active low, asynchronous
//   halted      in   high while the control FSM is in STOP
//   snot        out  one-cycle resume pulse, registered
//   key_db      out  debounced key level, 1 = pressed
//   halt_count  out  resumes issued, saturating at 255
//   run_cycles  out  cycles with halted low, wrapping (only with RESUME_CYCLE_COUNT_EN)
module resume_ctrl
    import resume_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_n,
    input  logic        halted,
    output logic        snot,
    output logic        key_db,
    output logic [7:0]  halt_count
`ifdef RESUME_CYCLE_COUNT_EN
    ,
    output logic [15:0] run_cycles
`endif
);

    state_t state;
    state_t state_next;
    logic   press;
    logic   fire;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key_debounce (
        .clock (clock),
        .reset (reset),
        .key_n (key_n),
        .key_db(key_db),
        .press (press)
    );

    // A press is only accepted while halted; otherwise it is dropped.
    // FIRED absorbs the cycle(s) between snot and halted falling so a held
    // key cannot issue a second resume.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (halted && press) begin
                    state_next = FIRED;
                    fire       = 1'b1;
                end else if (halted) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!halted) begin
                    state_next = IDLE;
                end else if (press) begin
                    state_next = FIRED;
                    fire       = 1'b1;
                end
            end
            FIRED: begin
                if (!halted) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snot       <= 1'b0;
            halt_count <= 8'd0;
        end else begin
            state <= state_next;
            snot  <= fire;
            if (fire && (halt_count != HALT_COUNT_MAX)) begin
                halt_count <= halt_count + 8'd1;
            end
        end
    end

`ifdef RESUME_CYCLE_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cycles <= 16'd0;
        end else if (!halted) begin
            run_cycles <= run_cycles + 16'd1;
        end
    end
`endif

endmodule
